// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_ctrl
//  Description : Parametrised SPI master. Shifts one DATA_W-bit word per
//                txstart in any SPI mode (cpol/cpha), MSB- or LSB-first,
//                with a programmable SCK divider and NUM_CS active-low
//                chip selects. cs_hold keeps CS asserted for bursts.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master_ctrl #(
  parameter int  DATA_W = 8,
  parameter int  DIV_W  = 8,
  parameter int  NUM_CS = 2,
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] txdata,
  input  logic              txstart,
  input  logic [DIV_W-1:0]  clkdiv,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cs_hold,
  output logic [DATA_W-1:0] rxdata,
  output logic              busy,
  output logic              done,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n
);

  // Edge counter must reach 2*DATA_W (all edges issued).
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_lead  = 2'd1;
  localparam logic [1:0] c_st_shift = 2'd2;
  localparam logic [1:0] c_st_trail = 2'd3;

  localparam logic [EDGE_W-1:0] c_all_edges  = EDGE_W'(2 * DATA_W);
  localparam logic [EDGE_W-1:0] c_final_done = EDGE_W'(2 * DATA_W - 1);

  // Control state
  logic [1:0]        r_state;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [EDGE_W-1:0] r_edge_cnt;   // number of SCK edges already issued

  // Configuration captured at accept
  logic [DIV_W-1:0]  r_clkdiv;
  logic              r_cpha;
  logic              r_lsb;

  // Datapath
  logic [DATA_W-1:0] r_tx_shift;
  logic [DATA_W-1:0] r_rx_shift;

  // Output registers
  logic [DATA_W-1:0] r_rxdata;
  logic              r_busy;
  logic              r_done;
  logic              r_sck;
  logic              r_mosi;
  logic [NUM_CS-1:0] r_cs_n;

  logic              w_accept;
  logic              w_tick;
  logic              w_edge;
  logic              w_leading;
  logic              w_first_edge;
  logic              w_last_edge;
  logic              w_sample;
  logic              w_advance;
  logic              w_finish;
  logic              w_next_bit;
  logic [DATA_W-1:0] w_tx_next;
  logic [DATA_W-1:0] w_rx_next;
  logic [NUM_CS-1:0] w_cs_dec;

  assign w_accept = (r_state == c_st_idle) & txstart;
  assign w_tick   = (r_div_cnt == r_clkdiv);

  // An edge is issued at the end of LEAD and at every SHIFT half-period
  // except the last one, which only closes out the final SCK phase.
  assign w_edge = w_tick & ((r_state == c_st_lead) |
                            ((r_state == c_st_shift) & (r_edge_cnt != c_all_edges)));

  // With k edges done, the edge being issued is k+1: odd numbers lead.
  assign w_leading    = ~r_edge_cnt[0];
  assign w_first_edge = (r_edge_cnt == '0);
  assign w_last_edge  = (r_edge_cnt == c_final_done);

  // cpha=0 samples on leading edges, cpha=1 on trailing edges.
  assign w_sample  = w_edge & (w_leading ^ r_cpha);
  assign w_advance = w_edge & (r_cpha ? (w_leading & ~w_first_edge)
                                      : (~w_leading & ~w_last_edge));

  assign w_finish = (r_state == c_st_trail) & w_tick;

  assign w_next_bit = r_lsb ? r_tx_shift[1] : r_tx_shift[DATA_W-2];
  assign w_tx_next  = r_lsb ? (r_tx_shift >> 1) : (r_tx_shift << 1);
  assign w_rx_next  = r_lsb ? {spi_miso, r_rx_shift[DATA_W-1:1]}
                            : {r_rx_shift[DATA_W-2:0], spi_miso};

  // Chip-select decode; an out-of-range select asserts nothing.
  for (genvar i = 0; i < NUM_CS; i++) begin : g_cs_dec
    localparam logic [CS_W-1:0] c_idx = CS_W'(i);
    assign w_cs_dec[i] = (cs_sel != c_idx);
  end

  // Half-period divider: restarts on accept so edge spacing never drifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if ((r_state == c_st_idle) || w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Transfer sequencing: IDLE -> LEAD -> SHIFT -> TRAIL -> IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_st_idle;
      r_edge_cnt <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (txstart) begin
            r_state    <= c_st_lead;
            r_edge_cnt <= '0;
          end
        end
        c_st_lead:  if (w_tick) r_state <= c_st_shift;
        c_st_shift: if (w_tick && (r_edge_cnt == c_all_edges)) r_state <= c_st_trail;
        c_st_trail: if (w_tick) r_state <= c_st_idle;
        default:    r_state <= c_st_idle;
      endcase
      if (w_edge) r_edge_cnt <= r_edge_cnt + EDGE_W'(1);
    end
  end

  // Capture the transfer configuration so later changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clkdiv <= '0;
      r_cpha   <= 1'b0;
      r_lsb    <= 1'b0;
    end else if (w_accept) begin
      r_clkdiv <= clkdiv;
      r_cpha   <= cpha;
      r_lsb    <= lsb_first;
    end
  end

  // Serial datapath: SCK toggling, MOSI shifting and MISO assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_mosi     <= 1'b0;
      r_sck      <= 1'b0;
    end else if (w_accept) begin
      r_tx_shift <= txdata;
      r_rx_shift <= '0;
      r_mosi     <= lsb_first ? txdata[0] : txdata[DATA_W-1];
      r_sck      <= cpol;
    end else if (r_state == c_st_idle) begin
      r_sck <= cpol;
    end else begin
      if (w_edge) r_sck <= ~r_sck;
      if (w_advance) begin
        r_tx_shift <= w_tx_next;
        r_mosi     <= w_next_bit;
      end
      if (w_sample) r_rx_shift <= w_rx_next;
    end
  end

  // Host-side status, result word and chip-select outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rxdata <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cs_n   <= '1;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_busy <= 1'b1;
        r_cs_n <= w_cs_dec;
      end else if (w_finish) begin
        r_busy   <= 1'b0;
        r_rxdata <= r_rx_shift;
        if (!cs_hold) r_cs_n <= '1;
      end else if ((r_state == c_st_idle) && !cs_hold) begin
        r_cs_n <= '1;
      end
    end
  end

  assign rxdata   = r_rxdata;
  assign busy     = r_busy;
  assign done     = r_done;
  assign spi_sck  = r_sck;
  assign spi_mosi = r_mosi;
  assign spi_cs_n = r_cs_n;

endmodule
`default_nettype wire
